inst_mem_loader: RTL and testbench
==================================

// Module: inst_mem_loader
// PURPOSE
//  Writer side of the instruction memory: accepts a program as a big-endian byte stream,
//  packs 4 bytes per MIPS word and issues one word write per word to the instruction RAM.
//  Holds the CPU (cpu_hold) until the requested number of words is written.
//  Sits between the boot/debug byte source and the instruction memory write port.
// PARAMETERS
//  DEPTH      64   instruction RAM depth in 32-bit words (max loadable word count)
//  BASE_ADDR  0    byte address of the first written word (word aligned)
// PORTS
//  clk         in   1   system clock, rising edge
//  rst_n       in   1   asynchronous active-low reset
//  start       in   1   1-cycle pulse: begin a load of word_count words
//  word_count  in   7   words to load; sampled only on an accepted start
//  byte_valid  in   1   byte_data holds a valid byte
//  byte_data   in   8   program byte, MSB-first per word
//  byte_ready  out  1   loader accepts a byte this cycle
//  mem_we      out  1   instruction RAM write enable, 1 cycle per word
//  mem_addr    out  32  byte address of the write (low 2 bits always 0)
//  mem_wdata   out  32  packed instruction word
//  busy        out  1   load in progress (RECV or WRITE)
//  done        out  1   load finished (held in DONE)
//  error       out  1   word_count > DEPTH on last start (held in DONE)
//  cpu_hold    out  1   keep the pipeline stalled/in reset while 1
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; byte_ready=0, mem_we=0, mem_addr=BASE_ADDR,
//   mem_wdata=0, busy=0, done=0, error=0, cpu_hold=1; byte and word counters cleared.
//  FSM states IDLE, RECV, WRITE, DONE:
//   IDLE : start=1 -> latch word_count into cnt, clear error/done.
//          cnt==0 -> DONE; cnt>DEPTH -> error=1, DONE (no writes); else RECV.
//   RECV : byte_ready=1. Byte accepted when byte_valid&byte_ready.
//          Byte k (0..3) of a word goes to wdata[31-8k -: 8] (first byte = [31:24]).
//          Acceptance of byte 3 -> WRITE next cycle.
//   WRITE: one cycle; mem_we=1, mem_addr=BASE_ADDR+4*word_idx, mem_wdata=packed word;
//          byte_ready=0. Then word_idx+1; if word_idx+1==cnt -> DONE else RECV.
//   DONE : done=1, cpu_hold=0, byte_ready=0. start=1 -> same handling as IDLE (reload).
//  Latency: byte 3 accepted in cycle N -> mem_we=1 in cycle N+1. Max rate 4 bytes / 5 cycles.
//  byte_valid gaps in RECV: byte counter holds; partial word retained, no timeout.
//  start while busy (RECV/WRITE): ignored; word_count not resampled.
//  byte_valid outside RECV: ignored (byte_ready=0, nothing consumed).
//  cpu_hold=1 in IDLE, RECV, WRITE; 0 only in DONE (including DONE with error=1).
//  busy=1 exactly in RECV and WRITE; done and busy never both 1.
//  mem_addr/mem_wdata hold their last values when mem_we=0; mem_we only ever high in WRITE.
//  Last word address = BASE_ADDR+4*(cnt-1); never exceeds BASE_ADDR+4*(DEPTH-1).
//  Reset mid-load: returns to IDLE immediately; words already written stay in RAM,
//   partial word discarded, cpu_hold=1 again.
// TESTING
//  1. start, word_count=2, bytes 20 08 00 05 8C 09 00 04 back-to-back -> mem_we at
//     addr 0x0 data 0x20080005, then addr 0x4 data 0x8C090004; done=1, cpu_hold=0.
//  2. word_count=1, byte_valid toggling 1/0 each cycle -> single write 0xAABBCCDD after
//     bytes AA BB CC DD; byte gaps do not advance packing.
//  3. word_count=0 -> DONE next cycle, no mem_we, error=0; word_count=65 -> DONE,
//     error=1, no mem_we, cpu_hold=0.
//  4. word_count=64 full load -> 64 writes, last at addr 0xFC, done=1 after last write.
//  5. start pulse during RECV with word_count=5 after initial 2 -> ignored; exactly 2 writes.
//  6. rst_n low after 6 bytes of 3-word load -> all outputs reset values same cycle;
//     new start with 1 word -> write at BASE_ADDR with fresh 4 bytes.

Source files
------------

// File: rtl/inst_mem_loader.sv
// inst_mem_loader
//   Writer side of the instruction memory. Takes a program as a big-endian
//   byte stream, packs 4 bytes per 32-bit word and issues one RAM write per
//   word. Holds the CPU (cpu_hold) until the requested word count is written.
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   start, word_count     begin a load of word_count words (sampled on start)
//   byte_valid, byte_data byte stream in, MSB-first per word
//   byte_ready            a byte is consumed when byte_valid & byte_ready
//   mem_we/addr/wdata     instruction RAM write port, one cycle per word
//   busy, done, error     status (error: last word_count exceeded DEPTH)
//   cpu_hold              keep the CPU stalled while 1
module inst_mem_loader #(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [6:0]  word_count,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_hold
);

  localparam logic [7:0] DEPTH_W = 8'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [6:0]  cnt;
  logic [6:0]  word_idx;
  logic [1:0]  byte_cnt;
  logic [23:0] pack;      // first three bytes of the word being assembled
  logic        accept;
  logic        start_ok;
  logic        too_big;

  assign accept   = (state == S_RECV) && byte_valid;
  // start is only honoured when no load is in flight
  assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));
  assign too_big  = {1'b0, word_count} > DEPTH_W;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          if (word_count == 7'd0 || too_big) state_nxt = S_DONE;
          else                               state_nxt = S_RECV;
        end
      end
      S_RECV:  if (accept && byte_cnt == 2'd3) state_nxt = S_WRITE;
      S_WRITE: state_nxt = (word_idx + 7'd1 == cnt) ? S_DONE : S_RECV;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      word_idx  <= '0;
      byte_cnt  <= '0;
      pack      <= '0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
      error     <= 1'b0;
    end else begin
      if (start_ok) begin
        cnt      <= word_count;
        word_idx <= '0;
        byte_cnt <= '0;
        error    <= too_big;
      end
      if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        // shifting in MSB-first puts byte 0 at [31:24] once all four arrive
        pack     <= {pack[15:0], byte_data};
        if (byte_cnt == 2'd3) begin
          // write port registered at the last byte so it is stable during
          // WRITE and holds afterwards
          mem_wdata <= {pack, byte_data};
          mem_addr  <= BASE_ADDR + {23'b0, word_idx, 2'b00};
        end
      end
      if (state == S_WRITE) word_idx <= word_idx + 7'd1;
    end
  end

  assign byte_ready = (state == S_RECV);
  assign mem_we     = (state == S_WRITE);
  assign busy       = (state == S_RECV) || (state == S_WRITE);
  assign done       = (state == S_DONE);
  assign cpu_hold   = (state != S_DONE);

endmodule

// File: tb/tb_inst_mem_loader.sv
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [6:0]  word_count;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_hold;

  int checks = 0;
  int errors = 0;

  // write log, appended on every observed write cycle
  int          wr_n = 0;
  logic [31:0] wr_addr [0:255];
  logic [31:0] wr_data [0:255];

  inst_mem_loader #(.DEPTH(64), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_we === 1'b1) begin
      wr_addr[wr_n[7:0]] = mem_addr;
      wr_data[wr_n[7:0]] = mem_wdata;
      wr_n = wr_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // called at a negedge; returns at the negedge after the byte is consumed
  task automatic put_byte(input logic [7:0] b);
    int guard;
    byte_valid = 1'b1;
    byte_data  = b;
    guard = 0;
    while (byte_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) chk("byte_ready_timeout", {31'b0, byte_ready}, 32'd1);
    @(negedge clk);
  endtask

  task automatic put_word(input logic [31:0] w);
    put_byte(w[31:24]);
    put_byte(w[23:16]);
    put_byte(w[15:8]);
    put_byte(w[7:0]);
  endtask

  task automatic do_start(input logic [6:0] wc);
    start      = 1'b1;
    word_count = wc;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (done !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("done_timeout", {31'b0, done}, 32'd1);
    @(negedge clk);
    #1;
  endtask

  initial begin
    int base;
    logic [31:0] w;

    rst_n = 1'b0; start = 1'b0; word_count = '0; byte_valid = 1'b0; byte_data = '0;
    #1;
    chk("rst_byte_ready", {31'b0, byte_ready}, 32'd0);
    chk("rst_mem_we",     {31'b0, mem_we},     32'd0);
    chk("rst_mem_addr",   mem_addr,            32'h0);
    chk("rst_mem_wdata",  mem_wdata,           32'h0);
    chk("rst_busy",       {31'b0, busy},       32'd0);
    chk("rst_done",       {31'b0, done},       32'd0);
    chk("rst_error",      {31'b0, error},      32'd0);
    chk("rst_cpu_hold",   {31'b0, cpu_hold},   32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_cpu_hold", {31'b0, cpu_hold}, 32'd1);

    // 1: two words back-to-back
    base = wr_n;
    do_start(7'd2);
    chk("t1_busy", {31'b0, busy}, 32'd1);
    put_byte(8'h20); put_byte(8'h08); put_byte(8'h00); put_byte(8'h05);
    chk("t1_latency_we",    {31'b0, mem_we}, 32'd1);
    chk("t1_latency_wdata", mem_wdata,       32'h20080005);
    chk("t1_write_noready", {31'b0, byte_ready}, 32'd0);
    put_byte(8'h8C); put_byte(8'h09); put_byte(8'h00); put_byte(8'h04);
    byte_valid = 1'b0;
    wait_done();
    chk("t1_nwr",   wr_n - base,         32'd2);
    chk("t1_addr0", wr_addr[base],       32'h0);
    chk("t1_data0", wr_data[base],       32'h20080005);
    chk("t1_addr1", wr_addr[base+1],     32'h4);
    chk("t1_data1", wr_data[base+1],     32'h8C090004);
    chk("t1_done",  {31'b0, done},       32'd1);
    chk("t1_busy0", {31'b0, busy},       32'd0);
    chk("t1_hold",  {31'b0, cpu_hold},   32'd0);
    chk("t1_error", {31'b0, error},      32'd0);
    chk("t1_addr_hold", mem_addr,        32'h4);

    // 2: one word with byte_valid gaps
    base = wr_n;
    do_start(7'd1);
    put_byte(8'hAA); byte_valid = 1'b0; @(negedge clk);
    put_byte(8'hBB); byte_valid = 1'b0; @(negedge clk);
    put_byte(8'hCC); byte_valid = 1'b0; @(negedge clk);
    chk("t2_gap_no_write", {31'b0, mem_we}, 32'd0);
    put_byte(8'hDD); byte_valid = 1'b0;
    wait_done();
    chk("t2_nwr",  wr_n - base,   32'd1);
    chk("t2_addr", wr_addr[base], 32'h0);
    chk("t2_data", wr_data[base], 32'hAABBCCDD);

    // 3: zero words, then oversize count
    base = wr_n;
    do_start(7'd0);
    #1;
    chk("t3_zero_done",  {31'b0, done},  32'd1);
    chk("t3_zero_error", {31'b0, error}, 32'd0);
    do_start(7'd65);
    #1;
    chk("t3_big_done",  {31'b0, done},     32'd1);
    chk("t3_big_error", {31'b0, error},    32'd1);
    chk("t3_big_hold",  {31'b0, cpu_hold}, 32'd0);
    @(negedge clk);
    chk("t3_nwr", wr_n - base, 32'd0);

    // 4: full 64-word load
    base = wr_n;
    do_start(7'd64);
    chk("t4_error_cleared", {31'b0, error}, 32'd0);
    for (int i = 0; i < 64; i++) begin
      w = {i[7:0], 8'hA5, 8'h5A, ~i[7:0]};
      put_word(w);
    end
    byte_valid = 1'b0;
    wait_done();
    chk("t4_nwr",       wr_n - base,        32'd64);
    chk("t4_first",     wr_data[base],      32'h00A55AFF);
    chk("t4_last_addr", wr_addr[base+63],   32'hFC);
    chk("t4_last_data", wr_data[base+63],   32'h3FA55AC0);
    chk("t4_done",      {31'b0, done},      32'd1);

    // 5: start during RECV is ignored
    base = wr_n;
    do_start(7'd2);
    put_byte(8'h11); put_byte(8'h22);
    byte_valid = 1'b0;
    do_start(7'd5);
    chk("t5_still_busy", {31'b0, busy}, 32'd1);
    put_byte(8'h33); put_byte(8'h44);
    put_word(32'h55667788);
    byte_valid = 1'b0;
    wait_done();
    chk("t5_nwr",   wr_n - base,     32'd2);
    chk("t5_data0", wr_data[base],   32'h11223344);
    chk("t5_data1", wr_data[base+1], 32'h55667788);

    // 6: reset mid-load, then fresh single-word load
    base = wr_n;
    do_start(7'd3);
    put_word(32'h01020304);
    put_byte(8'h05); put_byte(8'h06);
    byte_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy",  {31'b0, busy},       32'd0);
    chk("t6_rst_done",  {31'b0, done},       32'd0);
    chk("t6_rst_hold",  {31'b0, cpu_hold},   32'd1);
    chk("t6_rst_ready", {31'b0, byte_ready}, 32'd0);
    chk("t6_rst_we",    {31'b0, mem_we},     32'd0);
    chk("t6_rst_addr",  mem_addr,            32'h0);
    chk("t6_rst_wdata", mem_wdata,           32'h0);
    chk("t6_nwr_before", wr_n - base,        32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    base = wr_n;
    do_start(7'd1);
    put_word(32'hCAFEF00D);
    byte_valid = 1'b0;
    wait_done();
    chk("t6_nwr",  wr_n - base,   32'd1);
    chk("t6_addr", wr_addr[base], 32'h0);
    chk("t6_data", wr_data[base], 32'hCAFEF00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
